// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/DM request ports, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          if_stall;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          dm_stall;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF and DM ports of the 5-stage pipeline.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise DM has fixed priority.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int CW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          if_ack_q, if_ack_d;
   logic          dm_ack_q, dm_ack_d;
   logic          gnt_if, gnt_dm;

`ifdef MEM_ARB_RR_EN
   logic          last_dm_q, last_dm_d;
`endif

   // The ack cycle never grants: the requester still shows its old address.
   always_comb begin
      gnt_if = 1'b0;
      gnt_dm = 1'b0;
      if (state_q == IDLE && !(if_ack_q || dm_ack_q)) begin
`ifdef MEM_ARB_RR_EN
         if (bus.if_req && bus.dm_req) begin
            gnt_if = last_dm_q;
            gnt_dm = ~last_dm_q;
         end else begin
            gnt_if = bus.if_req;
            gnt_dm = bus.dm_req;
         end
`else
         gnt_dm = bus.dm_req;
         gnt_if = bus.if_req & ~bus.dm_req;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_dm) begin
               state_d = DM_BUSY;
               cnt_d   = CW'(MEM_LAT);
               rd_d    = ~bus.dm_we;
               wr_d    = bus.dm_we;
               addr_d  = bus.dm_addr;
               wdata_d = bus.dm_wdata;
            end else if (gnt_if) begin
               state_d = IF_BUSY;
               cnt_d   = CW'(MEM_LAT);
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               addr_d  = bus.if_addr;
            end
         end
         IF_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               if_rdata_d = bus.mem_rdata;
               if_ack_d   = 1'b1;
               rd_d       = 1'b0;
               wr_d       = 1'b0;
               state_d    = IDLE;
            end
         end
         DM_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               if (rd_q)
                  dm_rdata_d = bus.mem_rdata;
               dm_ack_d = 1'b1;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   always_comb begin
      last_dm_d = last_dm_q;
      if (gnt_dm)
         last_dm_d = 1'b1;
      else if (gnt_if)
         last_dm_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_dm_q <= 1'b1;
      else
         last_dm_q <= last_dm_d;
   end
`endif

   assign bus.mem_read  = rd_q;
   assign bus.mem_write = wr_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.if_stall  = bus.if_req & ~if_ack_q;
   assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1/2/3) sharing clock and reset.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   errors = 0;
   logic [31:0] mem1 [0:63];

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) b2 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
      .clk(clk), .reset(reset), .bus(b1));
   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u2 (
      .clk(clk), .reset(reset), .bus(b2));
   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
      .clk(clk), .reset(reset), .bus(b3));

   // Word memory behind u1: combinational read, write on the clock edge.
   always @(posedge clk)
      if (b1.mem_write) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
   assign b1.mem_rdata = mem1[b1.mem_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem1[i] = 32'h0;
      mem1[1]  = 32'h1111_1111;
      mem1[32] = 32'h2222_2222;
      b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
      b1.dm_addr = 0; b1.dm_wdata = 0;
      b2.if_req = 0; b2.if_addr = 0; b2.dm_req = 0; b2.dm_we = 0;
      b2.dm_addr = 0; b2.dm_wdata = 0; b2.mem_rdata = 0;
      b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
      b3.dm_addr = 0; b3.dm_wdata = 0; b3.mem_rdata = 0;

      // Reset state
      tick();
      chk("rst_mem_read", 32'(b2.mem_read), 32'h0);
      chk("rst_mem_write", 32'(b1.mem_write), 32'h0);
      chk("rst_mem_addr", b1.mem_addr, 32'h0);
      chk("rst_if_rdata", b2.if_rdata, 32'h0);
      chk("rst_dm_ack", 32'(b3.dm_ack), 32'h0);
      reset = 1'b0;
      tick();

      // Single fetch, MEM_LAT=2
      b2.mem_rdata = 32'h8C02_0004;
      b2.if_req = 1; b2.if_addr = 32'h40;
      tick();
      chk("f_mem_read", 32'(b2.mem_read), 32'h1);
      chk("f_mem_addr", b2.mem_addr, 32'h40);
      chk("f_stall1", 32'(b2.if_stall), 32'h1);
      chk("f_ack1", 32'(b2.if_ack), 32'h0);
      tick();
      chk("f_ack2", 32'(b2.if_ack), 32'h0);
      chk("f_stall2", 32'(b2.if_stall), 32'h1);
      tick();
      chk("f_ack3", 32'(b2.if_ack), 32'h1);
      chk("f_rdata", b2.if_rdata, 32'h8C02_0004);
      chk("f_stall3", 32'(b2.if_stall), 32'h0);
      chk("f_rd_off", 32'(b2.mem_read), 32'h0);
      b2.if_req = 0;
      tick();
      chk("f_ack_pulse", 32'(b2.if_ack), 32'h0);
      chk("f_rdata_hold", b2.if_rdata, 32'h8C02_0004);

      // Store then load, MEM_LAT=1
      b1.dm_req = 1; b1.dm_we = 1; b1.dm_addr = 32'h100;
      b1.dm_wdata = 32'hDEAD_BEEF;
      tick();
      chk("st_wr", 32'(b1.mem_write), 32'h1);
      chk("st_rd", 32'(b1.mem_read), 32'h0);
      chk("st_addr", b1.mem_addr, 32'h100);
      chk("st_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("st_ack", 32'(b1.dm_ack), 32'h1);
      chk("st_wr_off", 32'(b1.mem_write), 32'h0);
      chk("st_rdata_keep", b1.dm_rdata, 32'h0);
      b1.dm_we = 0;
      tick();
      chk("ackcyc_no_gnt", 32'(b1.mem_read), 32'h0);
      chk("ackcyc_ack_off", 32'(b1.dm_ack), 32'h0);
      tick();
      chk("ld_rd", 32'(b1.mem_read), 32'h1);
      chk("ld_wr", 32'(b1.mem_write), 32'h0);
      chk("ld_stall", 32'(b1.dm_stall), 32'h1);
      tick();
      chk("ld_ack", 32'(b1.dm_ack), 32'h1);
      chk("ld_rdata", b1.dm_rdata, 32'hDEAD_BEEF);
      b1.dm_req = 0;
      tick();

      // Both ports request together
      b1.if_req = 1; b1.if_addr = 32'h80;
      b1.dm_req = 1; b1.dm_addr = 32'h104;
`ifdef MEM_ARB_RR_EN
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_grant", b1.mem_addr, (k % 2 == 0) ? 32'h80 : 32'h104);
         tick();
         tick();
      end
      b1.if_req = 0; b1.dm_req = 0;
      tick();
`else
      tick();
      chk("tie_dm1", b1.mem_addr, 32'h104);
      chk("tie_if_stall1", 32'(b1.if_stall), 32'h1);
      tick();
      chk("tie_dm_ack1", 32'(b1.dm_ack), 32'h1);
      chk("tie_dm_rdata", b1.dm_rdata, 32'h1111_1111);
      tick();
      tick();
      chk("tie_dm2", b1.mem_addr, 32'h104);
      chk("tie_if_stall2", 32'(b1.if_stall), 32'h1);
      tick();
      chk("tie_dm_ack2", 32'(b1.dm_ack), 32'h1);
      b1.dm_req = 0;
      tick();
      chk("tie_gap", 32'(b1.mem_read), 32'h0);
      chk("tie_if_stall3", 32'(b1.if_stall), 32'h1);
      tick();
      chk("tie_if_gnt", b1.mem_addr, 32'h80);
      chk("tie_if_rd", 32'(b1.mem_read), 32'h1);
      tick();
      chk("tie_if_ack", 32'(b1.if_ack), 32'h1);
      chk("tie_if_rdata", b1.if_rdata, 32'h2222_2222);
      chk("tie_if_stall4", 32'(b1.if_stall), 32'h0);
      b1.if_req = 0;
      tick();
`endif

      // Request drops in first busy cycle, MEM_LAT=3
      b3.dm_req = 1; b3.dm_we = 1; b3.dm_addr = 32'h200;
      b3.dm_wdata = 32'h1234_5678;
      tick();
      chk("drop_wr", 32'(b3.mem_write), 32'h1);
      b3.dm_req = 0;
      tick();
      chk("drop_wr_hold", 32'(b3.mem_write), 32'h1);
      chk("drop_addr", b3.mem_addr, 32'h200);
      tick();
      chk("drop_no_ack", 32'(b3.dm_ack), 32'h0);
      tick();
      chk("drop_ack", 32'(b3.dm_ack), 32'h1);
      chk("drop_wr_off", 32'(b3.mem_write), 32'h0);
      tick();
      chk("drop_idle_ack", 32'(b3.dm_ack), 32'h0);
      chk("drop_idle_wr", 32'(b3.mem_write), 32'h0);

      // Reset in the middle of a DM write
      b3.dm_req = 1; b3.dm_we = 1; b3.dm_addr = 32'h300;
      tick();
      chk("ra_wr", 32'(b3.mem_write), 32'h1);
      chk("ra_stall", 32'(b3.dm_stall), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("ra_wr_async", 32'(b3.mem_write), 32'h0);
      chk("ra_addr", b3.mem_addr, 32'h0);
      chk("ra_ack", 32'(b3.dm_ack), 32'h0);
      tick();
      b3.dm_req = 0;
      reset = 1'b0;
      tick();
      chk("ra_idle_wr", 32'(b3.mem_write), 32'h0);
      chk("ra_idle_rd", 32'(b3.mem_read), 32'h0);
      tick();
      chk("ra_no_ack", 32'(b3.dm_ack), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
